// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Instruction prefetch stage between a synchronous instruction ROM (1-cycle
// read latency) and the fetch/decode stage of a 10-bit CPU. The block keeps
// the fetch PC, issues at most one ROM read per cycle while the queue has room
// for the word, and captures returned words with their PC in a small FIFO that
// decode pops from the head. A redirect flushes the queue and any in-flight
// word and restarts fetch at the target. Halt freezes issue only.
//
// Parameters
//   DEPTH     queue entries, power of 2 in 2..8
//   RESET_PC  fetch PC loaded on reset
//
// Ports
//   clk          in   clock, all state on posedge
//   rst          in   synchronous active-high reset
//   halted       in   no ROM issue while high
//   redirect     in   taken branch/jump from decode
//   redirect_pc  in   new fetch PC when redirect=1
//   rom_addr     out  ROM address (current fetch PC)
//   rom_en       out  ROM read issued this cycle
//   rom_data     in   ROM data, valid the cycle after rom_en
//   deq_ready    in   decode accepts the head entry this cycle
//   instr_valid  out  head entry valid (queue non-empty)
//   instr_out    out  head instruction (0 while empty)
//   instr_pc     out  PC of head instruction (0 while empty)
//
// Optional build macro PREFETCH_STATS_EN adds:
//   flush_cnt    out  [7:0]  redirects seen, saturating
//   stall_cnt    out  [15:0] cycles with instr_valid=0, not halted, not in
//                            reset; saturating
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [9:0]  RESET_PC = 10'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halted,
  input  logic        redirect,
  input  logic [9:0]  redirect_pc,
  output logic [9:0]  rom_addr,
  output logic        rom_en,
  input  logic [9:0]  rom_data,
  input  logic        deq_ready,
  output logic        instr_valid,
  output logic [9:0]  instr_out,
  output logic [9:0]  instr_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [7:0]  flush_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [9:0] instr;
    logic [9:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [9:0]    fetch_pc;
  logic [9:0]    issue_pc;
  logic          inflight;

  logic          push;
  logic          pop;
  logic [CW:0]   credits_used;

  // A slot is reserved for the word already in flight, so a read is only
  // issued when the queue can absorb it; capture never has to drop data.
  assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign rom_en       = !rst && !halted && !redirect && (credits_used < DEPTH_W);
  assign rom_addr     = fetch_pc;

  assign instr_valid  = (count != '0);
  assign pop          = instr_valid && deq_ready;
  // The word returning in a redirect cycle belongs to the abandoned path.
  assign push         = inflight && !redirect;

  assign instr_out    = instr_valid ? mem[head].instr : 10'd0;
  assign instr_pc     = instr_valid ? mem[head].pc    : 10'd0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      issue_pc <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect) begin
      // A pop in this cycle is subsumed by the flush: head jumps to tail.
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      head     <= tail;
    end else begin
      inflight <= rom_en;
      if (rom_en) begin
        issue_pc <= fetch_pc;
        fetch_pc <= fetch_pc + 10'd1;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are never observed
  // while count is zero because the outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[tail] <= '{instr: rom_data, pc: issue_pc};
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (redirect && (flush_cnt != 8'hFF)) flush_cnt <= flush_cnt + 8'd1;
      if (!instr_valid && !halted && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
